// File: rtl/pc_gen_pkg.sv
//------------------------------------------------------------------------------
// pc_gen_pkg : memory-map constants and redirect-source encoding for pc_gen
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pc_gen_pkg;

  localparam logic [31:0] TEXT_STARTADDR   = 32'h0000_3000;
  localparam logic [31:0] TEXT_ENDADDR     = 32'h0000_4FFC;
  localparam logic [31:0] EXC_HANDLER_ADDR = 32'h0000_4180;

  // Redirect source selected for the next PC; also handy on waveforms
  localparam int          SRC_W    = 3;
  localparam logic [2:0]  SRC_NONE = 3'd0;
  localparam logic [2:0]  SRC_EXC  = 3'd1;
  localparam logic [2:0]  SRC_ERET = 3'd2;
  localparam logic [2:0]  SRC_BR   = 3'd3;
  localparam logic [2:0]  SRC_PEND = 3'd4;
  localparam logic [2:0]  SRC_SEQ  = 3'd5;

endpackage

`default_nettype wire

// File: rtl/pc_gen_if.sv
//------------------------------------------------------------------------------
// pc_gen_if : redirect requests into, and fetch addresses out of, pc_gen
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pc_gen_if #(
  parameter int WIDTH = 32
);

  logic             en;
  logic             exc_req;
  logic             eret_req;
  logic [WIDTH-1:0] eret_target;
  logic             br_req;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_step;
  logic [WIDTH-1:0] pc_next;
  logic             redir_pending;
  logic             exc_adel;

  modport master (
    output en, exc_req, eret_req, eret_target, br_req, br_target,
    input  pc, pc_step, pc_next, redir_pending, exc_adel
  );

  modport slave (
    input  en, exc_req, eret_req, eret_target, br_req, br_target,
    output pc, pc_step, pc_next, redir_pending, exc_adel
  );

endinterface

`default_nettype wire

// File: rtl/pc_redirect_latch.sv
//------------------------------------------------------------------------------
// pc_redirect_latch : one-entry redirect target holder with pending flag
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_redirect_latch #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             set,
  input  wire logic             clear,
  input  wire logic [WIDTH-1:0] target_in,
  output logic                  pending,
  output logic [WIDTH-1:0]      target
);

  logic             r_pending = 1'b0;
  logic [WIDTH-1:0] r_target  = '0;

  // A set while already pending simply overwrites: newest branch wins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_target  <= '0;
    end else if (clear) begin
      r_pending <= 1'b0;
    end else if (set) begin
      r_pending <= 1'b1;
      r_target  <= target_in;
    end
  end

  assign pending = r_pending;
  assign target  = r_target;

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
//------------------------------------------------------------------------------
// pc_gen : IF-stage program counter with prioritised redirect and stall latch
// Optional fetch-address check enabled by macro PC_ALIGN_CHECK_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               STEP       = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(TEXT_STARTADDR),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_HANDLER_ADDR),
  parameter logic [WIDTH-1:0] TEXT_END   = WIDTH'(TEXT_ENDADDR)
) (
  input wire logic clk,
  input wire logic reset,
  pc_gen_if.slave  bus
);

  logic [WIDTH-1:0] r_pc = RESET_ADDR;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_next;
  logic [SRC_W-1:0] w_src;
  logic             w_pend;
  logic [WIDTH-1:0] w_pend_target;
  logic             w_latch_set;
  logic             w_latch_clr;

  assign w_step = r_pc + WIDTH'(STEP);

  always_comb begin
    w_src = SRC_NONE;
    if (bus.exc_req)       w_src = SRC_EXC;
    else if (bus.eret_req) w_src = SRC_ERET;
    else if (bus.en) begin
      if (bus.br_req)      w_src = SRC_BR;
      else if (w_pend)     w_src = SRC_PEND;
      else                 w_src = SRC_SEQ;
    end
  end

  always_comb begin
    w_next = r_pc;
    if (reset) begin
      w_next = RESET_ADDR;
    end else begin
      case (w_src)
        SRC_EXC:  w_next = EXC_VECTOR;
        SRC_ERET: w_next = bus.eret_target;
        SRC_BR:   w_next = bus.br_target;
        SRC_PEND: w_next = w_pend_target;
        SRC_SEQ:  w_next = w_step;
        default:  w_next = r_pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_pc <= w_next;
  end

  // Any taken redirect or any advance consumes (or supersedes) the latch
  assign w_latch_set = !bus.en && bus.br_req && !bus.exc_req && !bus.eret_req;
  assign w_latch_clr = bus.exc_req || bus.eret_req || bus.en;

  pc_redirect_latch #(
    .WIDTH (WIDTH)
  ) u_latch (
    .clk       (clk),
    .reset     (reset),
    .set       (w_latch_set),
    .clear     (w_latch_clr),
    .target_in (bus.br_target),
    .pending   (w_pend),
    .target    (w_pend_target)
  );

  assign bus.pc            = r_pc;
  assign bus.pc_step       = w_step;
  assign bus.pc_next       = w_next;
  assign bus.redir_pending = w_pend;

`ifdef PC_ALIGN_CHECK_EN
  logic r_adel = 1'b0;

  // Evaluated on pc_next so the registered flag lines up with the new pc
  always_ff @(posedge clk) begin
    if (reset) r_adel <= 1'b0;
    else       r_adel <= (w_next[1:0] != 2'b00) || (w_next < RESET_ADDR) ||
                         (w_next > TEXT_END);
  end

  assign bus.exc_adel = r_adel;
`else
  assign bus.exc_adel = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
//------------------------------------------------------------------------------
// tb_pc_gen : directed scoreboard bench for pc_gen
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_gen;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic        adel;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t        sb[$];
  logic [31:0] m_pc   = 32'h0000_3000;
  logic        m_pend = 1'b0;
  logic [31:0] m_tgt  = 32'h0;

  pc_gen_if #(.WIDTH(32)) bus();

  pc_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic bad_addr(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_4FFC);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, predict, check pc_next, then check registered outputs
  task automatic step(input logic r, input logic e, input logic x, input logic er,
                      input logic [31:0] et, input logic b, input logic [31:0] bt);
    exp_t        ex;
    logic [31:0] nxt;
    @(negedge clk);
    reset = r; bus.en = e; bus.exc_req = x; bus.eret_req = er;
    bus.eret_target = et; bus.br_req = b; bus.br_target = bt;
    nxt = m_pc;
    if (r) begin
      nxt = 32'h0000_3000; m_pend = 1'b0;
    end else if (x) begin
      nxt = 32'h0000_4180; m_pend = 1'b0;
    end else if (er) begin
      nxt = et; m_pend = 1'b0;
    end else if (e && b) begin
      nxt = bt; m_pend = 1'b0;
    end else if (e && m_pend) begin
      nxt = m_tgt; m_pend = 1'b0;
    end else if (e) begin
      nxt = m_pc + 32'd4;
    end else if (b) begin
      m_pend = 1'b1; m_tgt = bt;
    end
    #1;
    chk("pc_next", bus.pc_next, nxt);
    ex.pc = nxt; ex.pend = m_pend; ex.adel = r ? 1'b0 : bad_addr(nxt);
    sb.push_back(ex);
    m_pc = nxt;
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    chk("pc", bus.pc, ex.pc);
    chk("redir_pending", {31'b0, bus.redir_pending}, {31'b0, ex.pend});
    chk("exc_adel", {31'b0, bus.exc_adel}, {31'b0, ex.adel});
    chk("pc_step", bus.pc_step, ex.pc + 32'd4);
  endtask

  initial begin
    bus.en = 1'b0; bus.exc_req = 1'b0; bus.eret_req = 1'b0;
    bus.eret_target = 32'h0; bus.br_req = 1'b0; bus.br_target = 32'h0;
    #1;
    chk("pc_t0", bus.pc, 32'h0000_3000);
    chk("pend_t0", {31'b0, bus.redir_pending}, 32'h0);

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("pc_after_reset", bus.pc, 32'h0000_3000);
    repeat (3) step(0, 1, 0, 0, 0, 0, 0);
    chk("pc_seq3", bus.pc, 32'h0000_300C);

    // Stalled branch held two cycles, released by en
    step(0, 0, 0, 0, 0, 1, 32'h0000_3100);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("pc_stall_hold", bus.pc, 32'h0000_300C);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("pc_pend_release", bus.pc, 32'h0000_3100);

    // Exception beats eret and branch, and flushes a pending entry
    step(0, 0, 0, 0, 0, 1, 32'h0000_3100);
    step(0, 0, 1, 1, 32'h0000_3020, 1, 32'h0000_3100);
    chk("pc_exc_wins", bus.pc, 32'h0000_4180);
    step(0, 1, 0, 0, 0, 0, 0);

    // Newest stalled branch wins
    step(0, 0, 0, 0, 0, 1, 32'h0000_3100);
    step(0, 0, 0, 0, 0, 1, 32'h0000_3200);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("pc_newest_wins", bus.pc, 32'h0000_3200);

    // Reset discards a pending redirect
    step(0, 0, 0, 0, 0, 1, 32'h0000_3300);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("pc_reset_discard", bus.pc, 32'h0000_3004);

    // ERET alone while stalled, and branch during advance
    step(0, 0, 0, 1, 32'h0000_3020, 0, 0);
    step(0, 1, 0, 0, 0, 1, 32'h0000_3040);
    step(0, 0, 0, 1, 32'h0000_3060, 1, 32'h0000_3500);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("pc_eret_no_latch", bus.pc, 32'h0000_3064);

    // Modulo wrap of the sequential increment
    step(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("pc_wrap", bus.pc, 32'h0000_0000);

    // Fetch-address error boundaries
    step(0, 1, 0, 0, 0, 1, 32'h0000_3002);
    step(0, 1, 0, 0, 0, 1, 32'h0000_5000);
    step(0, 1, 0, 0, 0, 1, 32'h0000_4FF8);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("pc_past_text", bus.pc, 32'h0000_5000);
    step(0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
